// File: rtl/bp_fe_mem_responder_if.sv
// Command/response bundle between the FE pc_gen (master) and the fetch-side
// memory responder (slave).
interface bp_fe_mem_responder_if #(
  parameter int vaddr_width_p = 39,
  parameter int paddr_width_p = 40
);
  logic                       cmd_v_i;
  logic [1:0]                 cmd_op_i;
  logic [vaddr_width_p-1:0]   cmd_vaddr_i;
  logic [paddr_width_p-13:0]  cmd_fill_ptag_i;
  logic                       cmd_fill_x_i;
  logic                       cmd_fill_u_i;
  logic                       cmd_yumi_o;
  logic [1:0]                 priv_i;
  logic                       translation_en_i;
  logic                       poison_i;
  logic                       resp_v_o;
  logic [31:0]                resp_data_o;
  logic                       resp_icache_miss_o;
  logic                       resp_itlb_miss_o;
  logic                       resp_access_fault_o;
  logic                       resp_page_fault_o;

  modport master (
    output cmd_v_i, cmd_op_i, cmd_vaddr_i, cmd_fill_ptag_i, cmd_fill_x_i, cmd_fill_u_i,
    output priv_i, translation_en_i, poison_i,
    input  cmd_yumi_o, resp_v_o, resp_data_o, resp_icache_miss_o, resp_itlb_miss_o,
    input  resp_access_fault_o, resp_page_fault_o
  );

  modport slave (
    input  cmd_v_i, cmd_op_i, cmd_vaddr_i, cmd_fill_ptag_i, cmd_fill_x_i, cmd_fill_u_i,
    input  priv_i, translation_en_i, poison_i,
    output cmd_yumi_o, resp_v_o, resp_data_o, resp_icache_miss_o, resp_itlb_miss_o,
    output resp_access_fault_o, resp_page_fault_o
  );
endinterface

// File: rtl/bp_fe_mem_responder.sv
// Fetch-side memory responder: fully-associative ITLB, modeled direct-mapped
// I$ tags with a fixed refill stall, and a 2-cycle fetch response pipeline.
module bp_fe_mem_responder #(
  parameter int vaddr_width_p    = 39,
  parameter int paddr_width_p    = 40,
  parameter int tlb_els_p        = 8,
  parameter int icache_sets_p    = 64,
  parameter int mem_addr_width_p = 20,
  parameter int miss_latency_p   = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  bp_fe_mem_responder_if.slave        bus,
  output logic                        mem_r_v_o,
  output logic [mem_addr_width_p-1:0] mem_addr_o,
  input  logic [31:0]                 mem_data_i
);
  localparam int vtag_w_lp = vaddr_width_p - 12;
  localparam int ptag_w_lp = paddr_width_p - 12;
  localparam int idx_w_lp  = $clog2(icache_sets_p);
  localparam int itag_w_lp = paddr_width_p - 6 - idx_w_lp;
  localparam int rr_w_lp   = $clog2(tlb_els_p);
  localparam int cnt_w_lp  = $clog2(miss_latency_p + 1);
  localparam logic [1:0] op_fetch = 2'd0;
  localparam logic [1:0] op_fill  = 2'd1;
  localparam logic [1:0] op_fence = 2'd2;

  typedef enum logic {e_ready, e_refill} state_e;
  state_e state_r, state_n;
  logic [cnt_w_lp-1:0] cnt_r, cnt_n;
  logic refill_done;

  logic [tlb_els_p-1:0] tlb_v_r, tlb_x_r, tlb_u_r;
  logic [vtag_w_lp-1:0] tlb_vtag_r [tlb_els_p];
  logic [ptag_w_lp-1:0] tlb_ptag_r [tlb_els_p];
  logic [rr_w_lp-1:0]   rr_r, fill_idx;

  logic [icache_sets_p-1:0] ic_v_r;
  logic [itag_w_lp-1:0]     ic_tag_r [icache_sets_p];

  logic                     accept;
  logic                     vld_p1;
  logic [vaddr_width_p-1:0] vaddr_p1;
  logic                     tlb_hit, tlb_x, tlb_u;
  logic [ptag_w_lp-1:0]     tlb_ptag;
  logic [paddr_width_p-1:0] paddr;
  logic                     itlb_miss, page_fault, access_fault, exc;
  logic [idx_w_lp-1:0]      ic_idx;
  logic [itag_w_lp-1:0]     ic_tag;
  logic                     ic_hit, s2_miss, live_p1;
  logic                     vld_p2, ic_miss_p2, itlb_miss_p2, page_fault_p2, access_fault_p2;
  logic [idx_w_lp-1:0]      refill_idx_p2;
  logic [itag_w_lp-1:0]     refill_tag_p2;
  logic                     unused_paddr_lo;

  // S0: accept
  assign accept          = bus.cmd_v_i & reset_n_i & (state_r == e_ready);
  assign bus.cmd_yumi_o  = accept;

  // Fill target: an entry already holding this vtag, else first invalid, else round-robin.
  always_comb begin
    logic found_hit, found_inv;
    logic [rr_w_lp-1:0] hit_idx, inv_idx;
    found_hit = 1'b0;
    found_inv = 1'b0;
    hit_idx   = '0;
    inv_idx   = '0;
    for (int i = 0; i < tlb_els_p; i++) begin
      if (!tlb_v_r[i] && !found_inv) begin
        found_inv = 1'b1;
        inv_idx   = rr_w_lp'(i);
      end
      if (tlb_v_r[i] && tlb_vtag_r[i] == bus.cmd_vaddr_i[vaddr_width_p-1:12]) begin
        found_hit = 1'b1;
        hit_idx   = rr_w_lp'(i);
      end
    end
    fill_idx = found_hit ? hit_idx : (found_inv ? inv_idx : rr_r);
  end

  // S1: translate, check permissions and I$ tags, issue memory read
  always_comb begin
    tlb_hit  = 1'b0;
    tlb_ptag = '0;
    tlb_x    = 1'b0;
    tlb_u    = 1'b0;
    for (int i = 0; i < tlb_els_p; i++) begin
      if (tlb_v_r[i] && tlb_vtag_r[i] == vaddr_p1[vaddr_width_p-1:12]) begin
        tlb_hit  = 1'b1;
        tlb_ptag = tlb_ptag_r[i];
        tlb_x    = tlb_x_r[i];
        tlb_u    = tlb_u_r[i];
      end
    end
  end

  assign paddr        = bus.translation_en_i ? {tlb_ptag, vaddr_p1[11:0]}
                                             : {{(paddr_width_p-vaddr_width_p){1'b0}}, vaddr_p1};
  assign itlb_miss    = bus.translation_en_i & ~tlb_hit;
  assign page_fault   = bus.translation_en_i & tlb_hit & (~tlb_x | ((bus.priv_i == 2'd0) & ~tlb_u));
  assign access_fault = ~itlb_miss & ~page_fault & (|paddr[paddr_width_p-1:mem_addr_width_p+2]);
  assign exc          = itlb_miss | page_fault | access_fault;
  assign ic_idx       = paddr[6+idx_w_lp-1:6];
  assign ic_tag       = paddr[paddr_width_p-1:6+idx_w_lp];
  assign ic_hit       = ic_v_r[ic_idx] & (ic_tag_r[ic_idx] == ic_tag);
  // A miss leaving S2 squashes whatever sits in S1, as does a refill in progress.
  assign s2_miss      = vld_p2 & ic_miss_p2;
  assign live_p1      = vld_p1 & ~bus.poison_i & ~s2_miss & (state_r == e_ready);
  assign mem_r_v_o    = live_p1 & ~exc;
  assign mem_addr_o   = paddr[mem_addr_width_p+1:2];
  assign unused_paddr_lo = ^paddr[1:0];

  // S2: response
  assign bus.resp_v_o            = vld_p2;
  assign bus.resp_icache_miss_o  = vld_p2 & ic_miss_p2;
  assign bus.resp_itlb_miss_o    = vld_p2 & itlb_miss_p2;
  assign bus.resp_page_fault_o   = vld_p2 & page_fault_p2;
  assign bus.resp_access_fault_o = vld_p2 & access_fault_p2;
  assign bus.resp_data_o = (vld_p2 & ~ic_miss_p2 & ~itlb_miss_p2 & ~page_fault_p2 & ~access_fault_p2)
                           ? mem_data_i : 32'd0;

  always_comb begin
    state_n     = state_r;
    cnt_n       = cnt_r;
    refill_done = 1'b0;
    case (state_r)
      e_ready: begin
        if (s2_miss) begin
          state_n = e_refill;
          cnt_n   = '0;
        end
      end
      e_refill: begin
        if (cnt_r == cnt_w_lp'(miss_latency_p - 1)) begin
          refill_done = 1'b1;
          state_n     = e_ready;
          cnt_n       = '0;
        end else begin
          cnt_n = cnt_r + cnt_w_lp'(1);
        end
      end
      default: state_n = e_ready;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r <= e_ready;
      cnt_r   <= '0;
      tlb_v_r <= '0;
      rr_r    <= '0;
      ic_v_r  <= '0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      vld_p1  <= accept & (bus.cmd_op_i == op_fetch);
      vld_p2  <= live_p1;
      if (accept && bus.cmd_op_i == op_fill) begin
        tlb_v_r[fill_idx] <= 1'b1;
        rr_r              <= rr_r + rr_w_lp'(1);
      end else if (accept && bus.cmd_op_i == op_fence) begin
        tlb_v_r <= '0;
      end
      if (refill_done) ic_v_r[refill_idx_p2] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept && bus.cmd_op_i == op_fill) begin
      tlb_vtag_r[fill_idx] <= bus.cmd_vaddr_i[vaddr_width_p-1:12];
      tlb_ptag_r[fill_idx] <= bus.cmd_fill_ptag_i;
      tlb_x_r[fill_idx]    <= bus.cmd_fill_x_i;
      tlb_u_r[fill_idx]    <= bus.cmd_fill_u_i;
    end
    if (accept) vaddr_p1 <= bus.cmd_vaddr_i;
    ic_miss_p2      <= ~exc & ~ic_hit;
    itlb_miss_p2    <= itlb_miss;
    page_fault_p2   <= page_fault;
    access_fault_p2 <= access_fault;
    if (live_p1 && !exc && !ic_hit) begin
      refill_idx_p2 <= ic_idx;
      refill_tag_p2 <= ic_tag;
    end
    if (refill_done) ic_tag_r[refill_idx_p2] <= refill_tag_p2;
  end
endmodule

// File: tb/tb_bp_fe_mem_responder.sv
// Randomized scoreboard bench for bp_fe_mem_responder with a transaction-level
// ITLB/I$ reference model.
module tb_bp_fe_mem_responder;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_r_v;
  logic [19:0] mem_addr;
  logic [31:0] mem_data = 32'd0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic [3:0]  flags;   // {icache_miss, itlb_miss, page_fault, access_fault}
  } exp_t;
  exp_t q[$];

  // reference model state
  logic        m_tv [8];
  logic [26:0] m_tvt[8];
  logic [27:0] m_tpt[8];
  logic        m_tx [8];
  logic        m_tu [8];
  int          m_rr;
  logic        m_icv[64];
  logic [27:0] m_ict[64];

  bp_fe_mem_responder_if bus ();

  bp_fe_mem_responder dut (
    .clk_i      (clk),
    .reset_n_i  (reset_n),
    .bus        (bus),
    .mem_r_v_o  (mem_r_v),
    .mem_addr_o (mem_addr),
    .mem_data_i (mem_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memf(input logic [19:0] a);
    return {a[11:0], a} ^ 32'hC0DE_5A5A;
  endfunction

  always @(posedge clk) if (mem_r_v) mem_data <= memf(mem_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every response and flags late/missing ones.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        chk("resp_missing", 64'(cyc), 64'(e.cyc));
      end
      if (bus.resp_v_o) begin
        if (q.size() == 0) begin
          chk("resp_unexpected", 64'(bus.resp_v_o), 64'd0);
        end else begin
          e = q.pop_front();
          chk("resp_cycle", 64'(cyc), 64'(e.cyc));
          chk("resp_flags", 64'({bus.resp_icache_miss_o, bus.resp_itlb_miss_o,
                                 bus.resp_page_fault_o, bus.resp_access_fault_o}), 64'(e.flags));
          if (e.flags == 4'd0) chk("resp_data", 64'(bus.resp_data_o), 64'(e.data));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_tv[i] = 1'b0;
    for (int i = 0; i < 64; i++) m_icv[i] = 1'b0;
    m_rr = 0;
  endtask

  task automatic model_fill(input logic [26:0] vt, input logic [27:0] pt, input logic x, input logic u);
    int idx;
    idx = -1;
    for (int i = 0; i < 8; i++) if (m_tv[i] && m_tvt[i] == vt) idx = i;
    if (idx < 0) for (int i = 7; i >= 0; i--) if (!m_tv[i]) idx = i;
    if (idx < 0) idx = m_rr;
    m_tv[idx] = 1'b1; m_tvt[idx] = vt; m_tpt[idx] = pt; m_tx[idx] = x; m_tu[idx] = u;
    m_rr = (m_rr + 1) % 8;
  endtask

  task automatic model_fetch(input logic [38:0] va, input logic [1:0] pv, input logic tr,
                             output exp_t e, output bit inst, output int set, output logic [27:0] tg);
    logic [39:0] pa;
    int hi;
    e.cyc = 0; e.data = 32'd0; e.flags = 4'd0;
    inst = 0; set = 0; tg = '0;
    pa = {1'b0, va};
    if (tr) begin
      hi = -1;
      for (int i = 0; i < 8; i++) if (m_tv[i] && m_tvt[i] == va[38:12]) hi = i;
      if (hi < 0) e.flags[2] = 1'b1;
      else begin
        pa = {m_tpt[hi], va[11:0]};
        if (!m_tx[hi] || (pv == 2'd0 && !m_tu[hi])) e.flags[1] = 1'b1;
      end
    end
    if (e.flags == 4'd0 && pa[39:22] != 18'd0) e.flags[0] = 1'b1;
    if (e.flags == 4'd0) begin
      set = int'(pa[11:6]);
      tg  = pa[39:12];
      if (m_icv[set] && m_ict[set] == tg) e.data = memf(pa[21:2]);
      else begin e.flags[3] = 1'b1; inst = 1; end
    end
  endtask

  // Present one command and hold it until accepted; returns the accept cycle.
  task automatic send(input logic [1:0] op, input logic [38:0] va, input logic [27:0] pt,
                      input logic x, input logic u, output int acc);
    bus.cmd_v_i = 1'b1; bus.cmd_op_i = op; bus.cmd_vaddr_i = va;
    bus.cmd_fill_ptag_i = pt; bus.cmd_fill_x_i = x; bus.cmd_fill_u_i = u;
    acc = -1;
    for (int k = 0; k < 200 && acc < 0; k++) begin
      #1;
      if (bus.cmd_yumi_o) acc = cyc;
      @(posedge clk); #1;
    end
    bus.cmd_v_i = 1'b0;
    if (acc < 0) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic fetch(input logic [38:0] va, input logic [1:0] pv, input logic tr,
                       input logic pz, input bit spaced);
    exp_t e; bit inst; int set; logic [27:0] tg; int acc;
    bus.priv_i = pv; bus.translation_en_i = tr;
    send(2'd0, va, '0, 1'b0, 1'b0, acc);
    bus.poison_i = pz;
    model_fetch(va, pv, tr, e, inst, set, tg);
    e.cyc = acc + 2;
    if (!pz) begin
      q.push_back(e);
      if (inst) begin m_icv[set] = 1'b1; m_ict[set] = tg; end
    end
    if (spaced) begin
      idle(1);
      bus.poison_i = 1'b0;
      idle(1);
    end
  endtask

  task automatic fill(input logic [26:0] vt, input logic [27:0] pt, input logic x, input logic u);
    int acc;
    send(2'd1, {vt, 12'h000}, pt, x, u, acc);
    model_fill(vt, pt, x, u);
  endtask

  task automatic fence();
    int acc;
    send(2'd2, 39'd0, '0, 1'b0, 1'b0, acc);
    for (int i = 0; i < 8; i++) m_tv[i] = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.cmd_v_i = 1'b1; bus.cmd_op_i = 2'd3; bus.poison_i = 1'b0;
    idle(1);
    #1;
    chk("reset_yumi", 64'(bus.cmd_yumi_o), 64'd0);
    idle(2);
    chk("reset_resp_v", 64'(bus.resp_v_o), 64'd0);
    chk("reset_mem_r_v", 64'(mem_r_v), 64'd0);
    reset_n = 1'b1;
    bus.cmd_v_i = 1'b0;
    model_reset();
    idle(1);
  endtask

  initial begin
    int lows; bit seen;
    bus.cmd_v_i = 1'b0; bus.cmd_op_i = 2'd0; bus.cmd_vaddr_i = '0; bus.cmd_fill_ptag_i = '0;
    bus.cmd_fill_x_i = 1'b0; bus.cmd_fill_u_i = 1'b0; bus.priv_i = 2'd3;
    bus.translation_en_i = 1'b0; bus.poison_i = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // cold miss on 0x80, then measure the refill stall on yumi
    fetch(39'h80, 2'd3, 1'b0, 1'b0, 1'b0);
    bus.cmd_op_i = 2'd3; bus.cmd_v_i = 1'b1;
    lows = 0; seen = 0;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (!bus.cmd_yumi_o) begin lows++; seen = 1; end
      else if (seen) break;
      @(posedge clk); #1;
    end
    bus.cmd_v_i = 1'b0;
    chk("refill_stall_cycles", 64'(lows), 64'd16);
    idle(1);

    fetch(39'h80, 2'd3, 1'b0, 1'b0, 1'b0);
    chk("hit_mem_r_v", 64'(mem_r_v), 64'd1);
    chk("hit_mem_addr", 64'(mem_addr), 64'h20);
    idle(2);

    // back-to-back hits
    fetch(39'h80, 2'd3, 1'b0, 1'b0, 1'b0);
    fetch(39'h84, 2'd3, 1'b0, 1'b0, 1'b0);
    fetch(39'h88, 2'd3, 1'b0, 1'b0, 1'b1);

    // ITLB miss, page fault, translated fetch
    fetch(39'h4000_0000, 2'd3, 1'b1, 1'b0, 1'b1);
    fill(27'h40000, 28'h5, 1'b1, 1'b0);
    fetch(39'h4000_0000, 2'd0, 1'b1, 1'b0, 1'b1);
    fetch(39'h4000_0000, 2'd3, 1'b1, 1'b0, 1'b1);
    fetch(39'h4000_0000, 2'd3, 1'b1, 1'b0, 1'b1);

    // poison kills the older fetch, the younger one still responds
    fetch(39'h84, 2'd3, 1'b0, 1'b1, 1'b0);
    fetch(39'h88, 2'd3, 1'b0, 1'b0, 1'b1);

    // access fault: no memory read, no refill stall
    fetch(39'h40_0000, 2'd3, 1'b0, 1'b0, 1'b0);
    chk("af_mem_r_v", 64'(mem_r_v), 64'd0);
    idle(2);
    bus.cmd_op_i = 2'd3; bus.cmd_v_i = 1'b1; #1;
    chk("af_no_refill_yumi", 64'(bus.cmd_yumi_o), 64'd1);
    idle(1);
    bus.cmd_v_i = 1'b0;

    // reset in the middle of a refill
    fetch(39'h1000, 2'd3, 1'b0, 1'b0, 1'b0);
    idle(4);
    do_reset();
    fetch(39'h1000, 2'd3, 1'b0, 1'b0, 1'b1);

    // nine fills evict entry 0; fence clears everything
    for (int i = 0; i < 9; i++) fill(27'(27'h100 + i), 28'(i), 1'b1, 1'b1);
    fetch({27'h100, 12'h0}, 2'd3, 1'b1, 1'b0, 1'b1);
    fetch({27'h101, 12'h0}, 2'd3, 1'b1, 1'b0, 1'b1);
    fence();
    fetch({27'h101, 12'h0}, 2'd3, 1'b1, 1'b0, 1'b1);

    // randomized mix
    for (int n = 0; n < 300; n++) begin
      int r;
      logic [26:0] vt; logic [27:0] pt; logic [11:0] off; logic [38:0] va; logic tr;
      r   = $urandom_range(0, 99);
      vt  = 27'(27'h40000 + $urandom_range(0, 11));
      off = 12'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2));
      if (r < 15) begin
        pt = ($urandom_range(0, 9) == 0) ? 28'h400 : 28'($urandom_range(0, 7));
        fill(vt, pt, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      end else if (r < 18) begin
        fence();
      end else begin
        tr = 1'($urandom_range(0, 1));
        if (tr) va = {vt, off};
        else begin
          va = 39'(($urandom_range(0, 7) << 12) | off);
          if ($urandom_range(0, 7) == 0) va[22] = 1'b1;
        end
        fetch(va, 2'($urandom_range(0, 3)), tr, ($urandom_range(0, 7) == 0), 1'b1);
      end
    end

    idle(5);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
